pwm_peripheral: RTL and testbench

Consumes the five configuration bytes produced by the SPI register block and drives 16 output pins. Each pin is forced low, driven high, or driven by a shared 8-bit PWM waveform of about 3 kHz. The register bytes are written in the SPI/nCS domain, so they are double-flop synchronised and stability-qualified into the system clock domain. The duty cycle is shadowed so that it only changes at PWM period boundaries.

---
 rtl/pwm_peripheral.sv | 109 ++++++++++
 tb/tb_pwm_peripheral.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//
// Drives 16 output pins from five configuration bytes written by the SPI
// register block. Each pin is forced low, driven high, or driven by a shared
// 8-bit PWM waveform whose period is 256*CLK_DIV system clocks.
//
// The configuration bytes live in the SPI/nCS domain. All 40 bits are captured
// as one vector through two flops, and the applied copy only updates when both
// stages agree. A multi-bit update that straddles a sample edge is therefore
// never applied half-written. The duty cycle is additionally shadowed so a new
// value only takes effect at a PWM period boundary.
//
// Ports:
//   clk               system clock, all state updates on the rising edge
//   rst_n             synchronous active-low reset
//   en_reg_out_7_0    per-pin output enable, pins 7..0
//   en_reg_out_15_8   per-pin output enable, pins 15..8
//   en_reg_pwm_7_0    per-pin PWM select, pins 7..0
//   en_reg_pwm_15_8   per-pin PWM select, pins 15..8
//   pwm_duty_cycle    high time = duty/256 of a period (255 = constant high)
//   out               registered pin drive
// -----------------------------------------------------------------------------
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    typedef struct packed {
        logic [7:0]  duty;
        logic [15:0] en_pwm;
        logic [15:0] en_out;
    } cfg_t;

    cfg_t          cfg_in;
    cfg_t          sync1;
    cfg_t          sync2;
    cfg_t          applied;
    logic [PW-1:0] prescaler;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_shadow;
    logic          tick;
    logic          period_end;
    logic          pwm_sig;

    assign cfg_in = {pwm_duty_cycle,
                     en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

    always_comb begin
        tick       = (prescaler == PRE_LAST);
        // The edge where pwm_cnt wraps 255 -> 0 is the only point the shadow
        // may reload, so the waveform never changes shape mid-period.
        period_end = tick && (pwm_cnt == 8'hFF);
        // Duty 255 is special-cased so it is a true constant high instead of
        // dropping low for the single step where pwm_cnt == 255.
        pwm_sig    = (duty_shadow == 8'hFF) || (pwm_cnt < duty_shadow);
    end

    // NOTE: every register here, including the synchroniser stages, is
    // cleared by reset; the stages are plain flops, not a memory, so clearing
    // them costs nothing and guarantees applied starts from a known zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            applied     <= '0;
            prescaler   <= '0;
            pwm_cnt     <= '0;
            duty_shadow <= '0;
            out         <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync2 take the old sync1 and
            // the comparison below see both stages as they were before this
            // edge; blocking here would collapse the two stages into one.
            sync1 <= cfg_in;
            sync2 <= sync1;
            // Only a value seen identically on two consecutive edges is
            // applied; anything still changing is ignored.
            if (sync1 == sync2) begin
                applied <= sync2;
            end

            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (period_end) begin
                duty_shadow <= applied.duty;
            end

            // en_out low forces the pin low; otherwise en_pwm chooses between
            // the shared waveform and a constant high.
            out <= applied.en_out & (~applied.en_pwm | {16{pwm_sig}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//
// Self-checking bench for pwm_peripheral. A behavioural model derives the
// expected pin drive from elapsed clock counts (counter position, period
// boundaries) and from how long each input value has been held stable.
// Directed tasks additionally measure high/low times and latencies directly.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  eo_lo = '0;
    logic [7:0]  eo_hi = '0;
    logic [7:0]  ep_lo = '0;
    logic [7:0]  ep_hi = '0;
    logic [7:0]  duty  = '0;
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. m_steps counts edges since reset release, so the
    // PWM position is plain division of elapsed time. An input value is
    // applied once it has been sampled on two consecutive edges.
    // ------------------------------------------------------------------
    logic [39:0] m_in;
    logic [39:0] m_prev_in = '0;
    logic [39:0] m_applied = '0;
    int          m_stable  = 2;
    logic [7:0]  m_shadow  = '0;
    logic [7:0]  m_cnt;
    logic        m_wave;
    int unsigned m_steps   = 0;
    logic [15:0] exp_out   = '0;

    always @(posedge clk) begin
        m_in = {duty, ep_hi, ep_lo, eo_hi, eo_lo};
        if (!rst_n) begin
            m_prev_in = '0;
            m_applied = '0;
            m_stable  = 2;
            m_shadow  = '0;
            m_steps   = 0;
            exp_out   = '0;
        end else begin
            m_cnt  = 8'((m_steps / CLK_DIV) % 256);
            m_wave = (m_shadow == 8'hFF) || (m_cnt < m_shadow);
            for (int i = 0; i < 16; i++) begin
                if (!m_applied[i])          exp_out[i] = 1'b0;
                else if (!m_applied[16+i])  exp_out[i] = 1'b1;
                else                        exp_out[i] = m_wave;
            end
            if ((m_steps % PERIOD) == PERIOD - 1) m_shadow = m_applied[39:32];
            if (m_stable >= 2) m_applied = m_prev_in;
            m_stable  = (m_in == m_prev_in) ? ((m_stable >= 2) ? 2 : m_stable + 1) : 1;
            m_prev_in = m_in;
            m_steps   = m_steps + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive only, no comparisons)
    // ------------------------------------------------------------------
    task automatic drive_cfg(input logic [15:0] en_out, input logic [15:0] en_pwm,
                             input logic [7:0] d);
        {eo_hi, eo_lo} = en_out;
        {ep_hi, ep_lo} = en_pwm;
        duty           = d;
    endtask

    task automatic wait_rise(input int limit, output bit found);
        logic prev;
        found = 1'b0;
        prev  = out[0];
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!prev && out[0]) begin
                found = 1'b1;
                return;
            end
            prev = out[0];
        end
    endtask

    // Called right after a rise: counts the high run and the following low
    // run, ending on the next rise.
    task automatic measure_hi_lo(output int hi, output int lo);
        hi = 1;
        lo = 0;
        for (int i = 0; i < PERIOD + 10; i++) begin
            @(negedge clk);
            if (out[0]) hi++;
            else break;
        end
        lo = 1;
        for (int i = 0; i < PERIOD + 10; i++) begin
            @(negedge clk);
            if (!out[0]) lo++;
            else break;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        drive_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 16'h0000) begin
                failures++;
                $display("FAIL reset_out cycle %0d: out=%h expected 0000", i, out);
            end
        end
        drive_cfg(16'h0000, 16'h0000, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (dut.prescaler !== '0 || dut.pwm_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_counters: prescaler=%0d pwm_cnt=%0d expected 0 0",
                     dut.prescaler, dut.pwm_cnt);
        end
    endtask

    task automatic test_static;
        drive_cfg(16'h0001, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL static_early: out=%h expected 0000 after 3 edges", out);
        end
        @(negedge clk);
        checks++;
        if (out !== 16'h0001) begin
            failures++;
            $display("FAIL static_lo: out=%h expected 0001 after 4 edges", out);
        end
        drive_cfg(16'h8001, 16'h0000, 8'h00);
        repeat (4) @(negedge clk);
        checks++;
        if (out !== 16'h8001) begin
            failures++;
            $display("FAIL static_hi: out=%h expected 8001", out);
        end
    endtask

    task automatic test_pwm_50;
        bit found;
        int hi, lo, freq_dhz;
        drive_cfg(16'h0001, 16'h0001, 8'h80);
        wait_rise(3 * PERIOD, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pwm50_rise: out[0]=%b, no rising edge within %0d clks", out[0], 3 * PERIOD);
            return;
        end
        measure_hi_lo(hi, lo);
        checks++;
        if (hi !== 1664) begin
            failures++;
            $display("FAIL pwm50_high: high=%0d clks expected 1664", hi);
        end
        checks++;
        if (lo !== 1664) begin
            failures++;
            $display("FAIL pwm50_low: low=%0d clks expected 1664", lo);
        end
        // Frequency in 0.1 Hz units at a 10 MHz clock; 3004.8 Hz +-1%.
        freq_dhz = 100_000_000 / (hi + lo);
        checks++;
        if (freq_dhz < 29748 || freq_dhz > 30348) begin
            failures++;
            $display("FAIL pwm50_freq: freq=%0d dHz expected 30048 +-1%%", freq_dhz);
        end
    endtask

    task automatic test_duty_extremes;
        int bad;
        drive_cfg(16'h0001, 16'h0001, 8'h00);
        repeat (PERIOD + 20) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (out[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL duty00_const: %0d clks with out[0]=1 expected 0", bad);
        end
        drive_cfg(16'h0001, 16'h0001, 8'hFF);
        repeat (PERIOD + 20) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (out[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL dutyff_const: %0d clks with out[0]=0 expected 1", bad);
        end
    endtask

    task automatic test_shadowing;
        bit found;
        int hi, lo, hi2, lo2, bad;
        drive_cfg(16'h0001, 16'h0001, 8'h40);
        wait_rise(3 * PERIOD, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL shadow_rise: out[0]=%b, no rising edge within %0d clks", out[0], 3 * PERIOD);
            return;
        end
        // Count the current period, switching the duty 100 clks into it.
        hi = 1;
        for (int i = 0; i < PERIOD + 10; i++) begin
            @(negedge clk);
            if (hi == 100) duty = 8'hC0;
            if (out[0]) hi++;
            else break;
        end
        lo = 1;
        for (int i = 0; i < PERIOD + 10; i++) begin
            @(negedge clk);
            if (!out[0]) lo++;
            else break;
        end
        measure_hi_lo(hi2, lo2);
        checks++;
        if (hi !== 832) begin
            failures++;
            $display("FAIL shadow_cur_high: high=%0d clks expected 832", hi);
        end
        checks++;
        if (hi2 !== 2496) begin
            failures++;
            $display("FAIL shadow_next_high: high=%0d clks expected 2496", hi2);
        end
        drive_cfg(16'h0000, 16'h0001, 8'hC0);
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL enout_dominates: %0d clks with out[0]=1 expected 0", bad);
        end
    endtask

    task automatic test_unstable;
        int bad;
        drive_cfg(16'h0F00, 16'h0000, 8'h00);
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            drive_cfg((i % 2 == 0) ? 16'h00F0 : 16'h0F00, 16'h0000, 8'h00);
            @(negedge clk);
            if (out !== 16'h0F00 || out !== exp_out) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL unstable_hold: %0d clks deviated, out=%h expected 0f00", bad, out);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit hit;
        drive_cfg(16'h0001, 16'h0001, 8'h80);
        repeat (PERIOD + 20) @(negedge clk);
        hit = 1'b0;
        for (int i = 0; i < PERIOD + 10; i++) begin
            @(negedge clk);
            if (dut.pwm_cnt == 8'd100) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL rstmid_wait: pwm_cnt=%0d never reached 100", dut.pwm_cnt);
            return;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_out: out=%h expected 0000 on reset edge", out);
        end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * PERIOD + 100; i++) begin
            @(negedge clk);
            n++;
            if (out[0]) break;
        end
        // Shadow restarts at 0, loads 0x80 at the first boundary (edge PERIOD),
        // and out rises one edge later with pwm_cnt back at 0.
        checks++;
        if (n !== PERIOD + 1) begin
            failures++;
            $display("FAIL rstmid_phase: first rise at edge %0d expected %0d", n, PERIOD + 1);
        end
    endtask

    task automatic test_random;
        int bad, first, hold;
        logic [15:0] got, want;
        for (int w = 0; w < 4; w++) begin
            drive_cfg(16'($urandom), 16'($urandom),
                      (w == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
            hold  = $urandom_range(600, 3400);
            bad   = 0;
            first = -1;
            got   = '0;
            want  = '0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (out !== exp_out) begin
                    if (first < 0) begin
                        first = i;
                        got   = out;
                        want  = exp_out;
                    end
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_window %0d: %0d bad clks, first at %0d out=%h expected %h",
                         w, bad, first, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm_50();
        test_duty_extremes();
        test_shadowing();
        test_unstable();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
